// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types for the round-robin memory arbiter: memory bus payloads,
// their idle values and the arbiter state encoding.
package mem_rr_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef struct packed {
    logic              mem_valid;
    logic              mem_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_type;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester, memory and status signals of the round-robin arbiter.
// master is the arbiter's view, slave the surrounding system's view.
interface mem_rr_arbiter_if #(
  parameter int unsigned NPORT = 4
);
  import mem_rr_arbiter_pkg::*;

  localparam int unsigned PW = $clog2(NPORT);

  mem_in_type  [NPORT-1:0] req_in;
  mem_out_type [NPORT-1:0] req_out;
  mem_in_type              mem_in;
  mem_out_type             mem_out;
  logic        [PW-1:0]    grant_id;
  logic                    busy;
  logic                    timeout_err;
  logic                    overflow;

  modport master (
    input  req_in, mem_out,
    output req_out, mem_in, grant_id, busy, timeout_err, overflow
  );

  modport slave (
    output req_in, mem_out,
    input  req_out, mem_in, grant_id, busy, timeout_err, overflow
  );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Round-robin selector: first set bit of eligible scanning from ptr upward,
// wrapping modulo NPORT.
module mem_rr_arbiter_rr_pick #(
  parameter int unsigned NPORT = 4
) (
  input  logic [NPORT-1:0]         eligible,
  input  logic [$clog2(NPORT)-1:0] ptr,
  output logic [$clog2(NPORT)-1:0] grant,
  output logic                     found
);

  localparam int unsigned PW = $clog2(NPORT);

  always_comb begin
    int          idx;
    logic [PW-1:0] sel;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < int'(NPORT); k++) begin
      idx = (int'(ptr) + k) % int'(NPORT);
      sel = PW'(idx);
      if (!found && eligible[sel]) begin
        grant = sel;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory port between NPORT pulse-style
// requesters, with per-port request capture and a transaction watchdog.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NPORT   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  mem_rr_arbiter_if.master bus
);

  localparam int unsigned   PW       = $clog2(NPORT);
  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef struct packed {
    arb_state_type           state;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           grant;
    logic [CW-1:0]           counter;
    mem_in_type              cur;
    mem_in_type [NPORT-1:0]  hold;
  } reg_type;

  reg_type                 r, rin;
  logic [NPORT-1:0]        eligible;
  logic [PW-1:0]           pick;
  logic                    found;
  mem_in_type              mem_in_c;
  mem_out_type [NPORT-1:0] req_out_c;
  logic                    timeout_err_c;
  logic                    overflow_c;

  // Incoming pulses compete in the same cycle as held requests.
  always_comb begin
    for (int i = 0; i < int'(NPORT); i++) begin
      eligible[i] = r.hold[i].mem_valid | bus.req_in[i].mem_valid;
    end
  end

  mem_rr_arbiter_rr_pick #(.NPORT(NPORT)) u_pick (
    .eligible (eligible),
    .ptr      (r.ptr),
    .grant    (pick),
    .found    (found)
  );

  always_comb begin
    logic       issue;
    mem_in_type nxt;
    rin           = r;
    mem_in_c      = init_mem_in;
    timeout_err_c = 1'b0;
    overflow_c    = 1'b0;
    issue         = 1'b0;
    for (int i = 0; i < int'(NPORT); i++) begin
      req_out_c[i] = init_mem_out;
    end
    // A held request is older than a same-cycle pulse, so it goes first.
    nxt = r.hold[pick].mem_valid ? r.hold[pick] : bus.req_in[pick];

    unique case (r.state)
      ARB_IDLE: issue = found;
      ARB_BUSY: begin
        mem_in_c           = r.cur;
        mem_in_c.mem_valid = 1'b0;
        if (bus.mem_out.mem_ready) begin
          req_out_c[r.grant] = bus.mem_out;
          issue              = found;
          if (!found) rin.state = ARB_IDLE;
        end else if ((TIMEOUT != 0) && (r.counter == CNT_LAST)) begin
          req_out_c[r.grant].mem_ready = 1'b1;
          timeout_err_c                = 1'b1;
          rin.counter                  = '0;
          rin.state                    = ARB_DRAIN;
        end else if (r.counter != '1) begin
          rin.counter = r.counter + 1'b1;
        end
      end
      ARB_DRAIN: begin
        // Late responses for the abandoned transaction are swallowed here.
        if (bus.mem_out.mem_ready || (r.counter == CNT_LAST)) begin
          rin.counter = '0;
          rin.state   = ARB_IDLE;
        end else if (r.counter != '1) begin
          rin.counter = r.counter + 1'b1;
        end
      end
      default: rin.state = ARB_IDLE;
    endcase

    if (issue) begin
      mem_in_c                 = nxt;
      mem_in_c.mem_valid       = 1'b1;
      rin.cur                  = nxt;
      rin.hold[pick].mem_valid = 1'b0;
      rin.grant                = pick;
      rin.ptr                  = (pick == PW'(NPORT - 1)) ? '0 : pick + 1'b1;
      rin.counter              = '0;
      rin.state                = ARB_BUSY;
    end

    for (int i = 0; i < int'(NPORT); i++) begin
      if (bus.req_in[i].mem_valid) begin
        if (issue && (pick == PW'(i))) begin
          if (r.hold[i].mem_valid) rin.hold[i] = bus.req_in[i];
        end else begin
          if (r.hold[i].mem_valid) overflow_c = 1'b1;
          rin.hold[i] = bus.req_in[i];
        end
      end
    end

    // Combinational paths must not leak requests while reset is asserted.
    if (rst) begin
      mem_in_c      = init_mem_in;
      timeout_err_c = 1'b0;
      overflow_c    = 1'b0;
      for (int i = 0; i < int'(NPORT); i++) begin
        req_out_c[i] = init_mem_out;
      end
    end
  end

  // All-zero reset value encodes ARB_IDLE, ptr 0 and empty holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= '0;
    else     r <= rin;
  end

  assign bus.mem_in      = mem_in_c;
  assign bus.req_out     = req_out_c;
  assign bus.grant_id    = r.grant;
  assign bus.busy        = (r.state != ARB_IDLE);
  assign bus.timeout_err = timeout_err_c;
  assign bus.overflow    = overflow_c;

endmodule
